// File: rtl/warp_fetcher_pkg.sv
// warp_fetcher_pkg: shared compute-unit fetch types (warp slot state, fetch request) and helpers.
package warp_fetcher_pkg;

    localparam int unsigned DefPcWidth   = 32;
    localparam int unsigned DefWarpWidth = 32;
    localparam int unsigned DefNumWarps  = 8;

    typedef enum logic [1:0] {
        WS_FREE,
        WS_READY,
        WS_WAIT
    } warp_state_e;

    typedef struct packed {
        logic [DefPcWidth-1:0]           pc;
        logic [DefWarpWidth-1:0]         act_mask;
        logic [$clog2(DefNumWarps)-1:0]  warp_id;
        logic [$clog2(DefWarpWidth)-1:0] subwarp_id;
    } fetch_req_t;

    // Increment with wrap at n, for pointers over a non power-of-two range.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 == n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/warp_fetcher_if.sv
// warp_fetcher_if: fetch request channel between the fetcher and the instruction cache.
//   fe_valid/fe_pc/fe_act_mask/fe_warp_id/fe_subwarp_id : request, driven by the fetcher (master)
//   ic_ready                                              : cache accepts the request (slave)
interface warp_fetcher_if #(
    parameter int unsigned PcWidth        = 32,
    parameter int unsigned WarpWidth      = 32,
    parameter int unsigned WidWidth       = 3,
    parameter int unsigned SubwarpIdWidth = 5
) ();

    logic                      fe_valid;
    logic [PcWidth-1:0]        fe_pc;
    logic [WarpWidth-1:0]      fe_act_mask;
    logic [WidWidth-1:0]       fe_warp_id;
    logic [SubwarpIdWidth-1:0] fe_subwarp_id;
    logic                      ic_ready;

    modport master (
        output fe_valid, fe_pc, fe_act_mask, fe_warp_id, fe_subwarp_id,
        input  ic_ready
    );

    modport slave (
        input  fe_valid, fe_pc, fe_act_mask, fe_warp_id, fe_subwarp_id,
        output ic_ready
    );

endinterface

// File: rtl/warp_fetcher_rr_warp_arbiter.sv
// rr_warp_arbiter: round-robin find-first over a request vector starting at a pointer.
//   req_i   : per-warp request (READY) vector
//   start_i : index searched first; search wraps modulo N
//   valid_o : some request is set
//   idx_o   : first set index at or after start_i
module rr_warp_arbiter #(
    parameter int unsigned N = 8,
    parameter int unsigned W = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    // Scan from farthest to nearest so the nearest request wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (req_i[(int'(start_i) + k) % int'(N)]) begin
                valid_o = 1'b1;
                idx_o   = W'((int'(start_i) + k) % int'(N));
            end
        end
    end

endmodule

// File: rtl/warp_fetcher.sv
// warp_fetcher: per-warp PC/mask/subwarp slots with round-robin fetch issue to the instruction cache.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   start_*            : launch a warp into the lowest FREE slot (start_warp_id_o shows the slot)
//   fe (master)        : fetch request to the instruction cache, held stable until ic_ready
//   upd_*              : single-cycle re-arm (or stop) of a warp waiting on its fetch
//   warp_active_o      : per-slot "not FREE" flags
// Optional: WARP_FETCHER_UPD_BYPASS_EN lets a non-stop update issue in the same cycle.
module warp_fetcher
    import warp_fetcher_pkg::*;
#(
    parameter  int unsigned PcWidth        = 32,
    parameter  int unsigned NumWarps       = 8,
    parameter  int unsigned WarpWidth      = 32,
    localparam int unsigned WidWidth       = NumWarps > 1 ? $clog2(NumWarps) : 1,
    localparam int unsigned SubwarpIdWidth = WarpWidth > 1 ? $clog2(WarpWidth) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_valid_i,
    output logic                      start_ready_o,
    input  logic [PcWidth-1:0]        start_pc_i,
    input  logic [WarpWidth-1:0]      start_act_mask_i,
    output logic [WidWidth-1:0]       start_warp_id_o,
    warp_fetcher_if.master            fe,
    input  logic                      upd_valid_i,
    input  logic [WidWidth-1:0]       upd_warp_id_i,
    input  logic [PcWidth-1:0]        upd_pc_i,
    input  logic [WarpWidth-1:0]      upd_act_mask_i,
    input  logic [SubwarpIdWidth-1:0] upd_subwarp_id_i,
    input  logic                      upd_stop_i,
    output logic [NumWarps-1:0]       warp_active_o
);

    warp_state_e               state_q [NumWarps];
    logic [PcWidth-1:0]        pc_q    [NumWarps];
    logic [WarpWidth-1:0]      mask_q  [NumWarps];
    logic [SubwarpIdWidth-1:0] sub_q   [NumWarps];
    logic                      lock_q;
    logic [WidWidth-1:0]       sel_q, rr_q;
    logic [NumWarps-1:0]       free_v, ready_v;
    logic                      arb_valid, valid, fire, start_fire, upd_hit, upd_load, byp_sel;
    logic [WidWidth-1:0]       arb_idx, sel_id;

    // Updates only count for a warp that is waiting on its fetch.
    assign upd_hit    = upd_valid_i && 32'(upd_warp_id_i) < NumWarps && state_q[upd_warp_id_i] == WS_WAIT;
    assign upd_load   = upd_hit && !upd_stop_i;
    assign start_fire = start_valid_i && start_ready_o;

    always_comb begin
        for (int i = 0; i < int'(NumWarps); i++) begin
            free_v[i]  = state_q[i] == WS_FREE;
            ready_v[i] = state_q[i] == WS_READY;
        end
`ifdef WARP_FETCHER_UPD_BYPASS_EN
        if (upd_load) ready_v[upd_warp_id_i] = 1'b1;
`endif
    end

    // Lowest FREE slot: scan high to low so the lowest index wins.
    always_comb begin
        start_warp_id_o = '0;
        for (int i = int'(NumWarps) - 1; i >= 0; i--)
            if (free_v[i]) start_warp_id_o = WidWidth'(i);
    end

    assign start_ready_o = |free_v;
    assign warp_active_o = ~free_v;

    rr_warp_arbiter #(
        .N (NumWarps),
        .W (WidWidth)
    ) u_arb (
        .req_i   (ready_v),
        .start_i (rr_q),
        .valid_o (arb_valid),
        .idx_o   (arb_idx)
    );

    // A stalled request keeps its warp so the payload cannot change under the cache.
    assign sel_id = lock_q ? sel_q : arb_idx;
    assign valid  = lock_q || arb_valid;
    assign fire   = valid && fe.ic_ready;

`ifdef WARP_FETCHER_UPD_BYPASS_EN
    assign byp_sel = upd_load && upd_warp_id_i == sel_id;
`else
    assign byp_sel = 1'b0;
`endif

    assign fe.fe_valid      = valid;
    assign fe.fe_warp_id    = valid ? sel_id : '0;
    assign fe.fe_pc         = !valid ? '0 : byp_sel ? upd_pc_i : pc_q[sel_id];
    assign fe.fe_act_mask   = !valid ? '0 : byp_sel ? upd_act_mask_i : mask_q[sel_id];
    assign fe.fe_subwarp_id = !valid ? '0 : byp_sel ? upd_subwarp_id_i : sub_q[sel_id];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
            sel_q  <= '0;
            rr_q   <= '0;
            for (int i = 0; i < int'(NumWarps); i++) begin
                state_q[i] <= WS_FREE;
                pc_q[i]    <= '0;
                mask_q[i]  <= '0;
                sub_q[i]   <= '0;
            end
        end else begin
            lock_q <= valid && !fe.ic_ready;
            sel_q  <= sel_id;
            if (fire) rr_q <= WidWidth'(wrap_inc(32'(sel_id), NumWarps));
            for (int i = 0; i < int'(NumWarps); i++) begin
                if (start_fire && start_warp_id_o == WidWidth'(i)) begin
                    state_q[i] <= WS_READY;
                    pc_q[i]    <= start_pc_i;
                    mask_q[i]  <= start_act_mask_i;
                    sub_q[i]   <= '0;
                end else begin
                    if (upd_load && upd_warp_id_i == WidWidth'(i)) begin
                        pc_q[i]   <= upd_pc_i;
                        mask_q[i] <= upd_act_mask_i;
                        sub_q[i]  <= upd_subwarp_id_i;
                    end
                    // Issue wins: with bypass, a warp re-armed and fetched this cycle goes straight back to WAIT.
                    if (fire && sel_id == WidWidth'(i))
                        state_q[i] <= WS_WAIT;
                    else if (upd_hit && upd_warp_id_i == WidWidth'(i))
                        state_q[i] <= upd_stop_i ? WS_FREE : WS_READY;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && upd_valid_i)
            assert (upd_hit) else $warning("warp_fetcher: update to warp %0d not in WAIT ignored", upd_warp_id_i);
    end

endmodule

// File: tb/tb_warp_fetcher.sv
// tb_warp_fetcher: directed self-checking bench for warp_fetcher.
module tb_warp_fetcher;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_valid_i;
    logic        start_ready_o;
    logic [31:0] start_pc_i;
    logic [31:0] start_act_mask_i;
    logic [2:0]  start_warp_id_o;
    logic        upd_valid_i;
    logic [2:0]  upd_warp_id_i;
    logic [31:0] upd_pc_i;
    logic [31:0] upd_act_mask_i;
    logic [4:0]  upd_subwarp_id_i;
    logic        upd_stop_i;
    logic [7:0]  warp_active_o;
    int          checks = 0;
    int          errors = 0;
    int          exp_pc [4];
    int          exp_sub [4];
    logic [31:0] exp_mask [4];
    int          hw [12];
    int          hpc [12];
    int          hsub [12];

    warp_fetcher_if fe_bus ();

    warp_fetcher dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .start_valid_i    (start_valid_i),
        .start_ready_o    (start_ready_o),
        .start_pc_i       (start_pc_i),
        .start_act_mask_i (start_act_mask_i),
        .start_warp_id_o  (start_warp_id_o),
        .fe               (fe_bus.master),
        .upd_valid_i      (upd_valid_i),
        .upd_warp_id_i    (upd_warp_id_i),
        .upd_pc_i         (upd_pc_i),
        .upd_act_mask_i   (upd_act_mask_i),
        .upd_subwarp_id_i (upd_subwarp_id_i),
        .upd_stop_i       (upd_stop_i),
        .warp_active_o    (warp_active_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start(input logic [31:0] pc, input logic [31:0] mask);
        start_valid_i    = 1'b1;
        start_pc_i       = pc;
        start_act_mask_i = mask;
    endtask

    task automatic upd(input int w, input logic [31:0] pc, input logic [31:0] mask, input int sub, input logic stop);
        upd_valid_i      = 1'b1;
        upd_warp_id_i    = 3'(w);
        upd_pc_i         = pc;
        upd_act_mask_i   = mask;
        upd_subwarp_id_i = 5'(sub);
        upd_stop_i       = stop;
    endtask

    task automatic do_reset(input logic ic_rdy);
        rst_ni        = 1'b0;
        start_valid_i = 1'b0;
        start_pc_i    = '0;
        start_act_mask_i = '0;
        upd_valid_i   = 1'b0;
        upd_warp_id_i = '0;
        upd_pc_i      = '0;
        upd_act_mask_i = '0;
        upd_subwarp_id_i = '0;
        upd_stop_i    = 1'b0;
        fe_bus.ic_ready = ic_rdy;
        repeat (2) tick();
        chk("rst_fe_valid", fe_bus.fe_valid, 0);
        chk("rst_fe_pc", fe_bus.fe_pc, 0);
        chk("rst_fe_mask", fe_bus.fe_act_mask, 0);
        chk("rst_fe_wid", fe_bus.fe_warp_id, 0);
        chk("rst_fe_sub", fe_bus.fe_subwarp_id, 0);
        chk("rst_start_ready", start_ready_o, 1);
        chk("rst_start_id", start_warp_id_o, 0);
        chk("rst_active", warp_active_o, 0);
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // First warp: start, issue next cycle, then wait.
        do_reset(1'b1);
        tick();
        start(32'h100, 32'hFFFF_FFFF);
        #1;
        chk("p1_start_id", start_warp_id_o, 0);
        chk("p1_no_same_cycle", fe_bus.fe_valid, 0);
        tick();
        start_valid_i = 1'b0;
        #1;
        chk("p1_fe_valid", fe_bus.fe_valid, 1);
        chk("p1_fe_pc", fe_bus.fe_pc, 32'h100);
        chk("p1_fe_wid", fe_bus.fe_warp_id, 0);
        chk("p1_fe_mask", fe_bus.fe_act_mask, 32'hFFFF_FFFF);
        chk("p1_active", warp_active_o, 8'h01);
        tick();
        chk("p1_wait_valid", fe_bus.fe_valid, 0);
        chk("p1_wait_active", warp_active_o, 8'h01);

        // Four warps round robin with updates returning PC+1 two cycles after issue.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_pc[i]   = (i + 1) << 12;
            exp_sub[i]  = 0;
            exp_mask[i] = 32'hF << (4 * i);
            start(32'(exp_pc[i]), exp_mask[i]);
            #1;
            chk("p2_start_id", start_warp_id_o, 64'(i));
        end
        tick();
        start_valid_i   = 1'b0;
        fe_bus.ic_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c >= 2) upd(hw[c-2], 32'(hpc[c-2]), exp_mask[hw[c-2]], hsub[c-2], 1'b0);
            else upd_valid_i = 1'b0;
            #1;
            chk("p2_fe_valid", fe_bus.fe_valid, 1);
            chk("p2_fe_wid", fe_bus.fe_warp_id, 64'(c % 4));
            chk("p2_fe_pc", fe_bus.fe_pc, 64'(exp_pc[c % 4]));
            chk("p2_fe_sub", fe_bus.fe_subwarp_id, 64'(exp_sub[c % 4]));
            chk("p2_fe_mask", fe_bus.fe_act_mask, 64'(exp_mask[c % 4]));
            exp_pc[c % 4]++;
            exp_sub[c % 4]++;
            hw[c]   = c % 4;
            hpc[c]  = exp_pc[c % 4];
            hsub[c] = exp_sub[c % 4];
            tick();
        end
        upd_valid_i = 1'b0;

        // Stall with warp 2 selected while warp 1 (nearer the pointer) becomes READY.
        do_reset(1'b1);
        tick();
        start(32'hA00, 32'h1);
        #1;
        chk("p3_start0", start_warp_id_o, 0);
        tick();
        start(32'hB00, 32'h2);
        #1;
        chk("p3_start1", start_warp_id_o, 1);
        chk("p3_issue0", fe_bus.fe_pc, 32'hA00);
        tick();
        start_valid_i = 1'b0;
        upd(0, 32'hA04, 32'h1, 1, 1'b0);
        #1;
        chk("p3_issue1", fe_bus.fe_warp_id, 1);
        tick();
        upd_valid_i = 1'b0;
        start(32'hC00, 32'h4);
        #1;
        chk("p3_start2", start_warp_id_o, 2);
        chk("p3_reissue0", fe_bus.fe_pc, 32'hA04);
        tick();
        start_valid_i   = 1'b0;
        fe_bus.ic_ready = 1'b0;
        upd(1, 32'hB04, 32'h2, 1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("p3_hold_wid", fe_bus.fe_warp_id, 2);
            chk("p3_hold_pc", fe_bus.fe_pc, 32'hC00);
            chk("p3_hold_mask", fe_bus.fe_act_mask, 32'h4);
            tick();
            upd_valid_i = 1'b0;
        end
        fe_bus.ic_ready = 1'b1;
        #1;
        chk("p3_release_wid", fe_bus.fe_warp_id, 2);
        tick();
        chk("p3_next_wid", fe_bus.fe_warp_id, 1);
        chk("p3_next_pc", fe_bus.fe_pc, 32'hB04);

        // All eight active, stop warp 3, its slot is reused.
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            start(32'(32'h40 * i), 32'hFFFF_FFFF);
            #1;
            chk("p4_start_id", start_warp_id_o, 64'(i));
        end
        tick();
        start_valid_i = 1'b0;
        #1;
        chk("p4_full_ready", start_ready_o, 0);
        chk("p4_full_active", warp_active_o, 8'hFF);
        tick();
        upd(3, 32'h0, 32'h0, 0, 1'b1);
        #1;
        chk("p4_stop_same_cycle", start_ready_o, 0);
        chk("p4_all_wait", fe_bus.fe_valid, 0);
        tick();
        upd_valid_i = 1'b0;
        #1;
        chk("p4_freed_ready", start_ready_o, 1);
        chk("p4_freed_id", start_warp_id_o, 3);
        chk("p4_freed_active", warp_active_o, 8'hF7);
        start(32'h777, 32'h5);
        tick();
        start_valid_i = 1'b0;
        #1;
        chk("p4_refill_active", warp_active_o, 8'hFF);
        chk("p4_refill_ready", start_ready_o, 0);
        chk("p4_refill_wid", fe_bus.fe_warp_id, 3);
        chk("p4_refill_pc", fe_bus.fe_pc, 32'h777);

        // Updates to a READY warp are ignored.
        do_reset(1'b0);
        tick();
        start(32'h300, 32'h3);
        tick();
        start_valid_i = 1'b0;
        upd(0, 32'h999, 32'h0, 7, 1'b0);
        #1;
        chk("p5_pc_same_cycle", fe_bus.fe_pc, 32'h300);
        tick();
        upd(0, 32'h999, 32'h0, 7, 1'b1);
        #1;
        chk("p5_pc_kept", fe_bus.fe_pc, 32'h300);
        chk("p5_sub_kept", fe_bus.fe_subwarp_id, 0);
        tick();
        upd_valid_i = 1'b0;
        #1;
        chk("p5_still_active", warp_active_o, 8'h01);
        chk("p5_still_valid", fe_bus.fe_valid, 1);
        chk("p5_pc_final", fe_bus.fe_pc, 32'h300);

        // Update-to-issue latency for a sole warp.
        do_reset(1'b1);
        tick();
        start(32'h10, 32'h1);
        tick();
        start_valid_i = 1'b0;
        #1;
        chk("p6_issue", fe_bus.fe_pc, 32'h10);
        tick();
        chk("p6_waiting", fe_bus.fe_valid, 0);
        upd(0, 32'h200, 32'h1, 2, 1'b0);
        #1;
`ifdef WARP_FETCHER_UPD_BYPASS_EN
        chk("p6_byp_valid_n", fe_bus.fe_valid, 1);
        chk("p6_byp_pc_n", fe_bus.fe_pc, 32'h200);
        tick();
        upd_valid_i = 1'b0;
        #1;
        chk("p6_byp_valid_n1", fe_bus.fe_valid, 0);
`else
        chk("p6_valid_n", fe_bus.fe_valid, 0);
        tick();
        upd_valid_i = 1'b0;
        #1;
        chk("p6_valid_n1", fe_bus.fe_valid, 1);
        chk("p6_pc_n1", fe_bus.fe_pc, 32'h200);
        chk("p6_sub_n1", fe_bus.fe_subwarp_id, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
